// File: rtl/dmem_access_ctrl_if.sv
// Core-side request/response bus of the data-memory sequencer.
// The master is the datapath and the slave is dmem_access_ctrl.
interface dmem_access_ctrl_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
);
    logic              req_valid;
    logic              req_write;
    logic              req_double;
    logic [AW-1:0]     req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [2*DW-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_write, req_double, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_double, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences single/double-word loads and stores onto a single-port synchronous SRAM.
// A double is issued as two big-endian beats and its read result is reassembled to 64 bits.
module dmem_access_ctrl #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_access_ctrl_if.slave    bus,
    output logic                 CEN,
    output logic                 WEN,
    output logic                 OEN,
    output logic [AW-1:0]        A,
    output logic [DW-1:0]        Data2Mem,
    input  logic [DW-1:0]        ReadDataMem
);

    typedef enum logic [2:0] {IDLE, B0, B1, RSP, ERR} state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic            double_q, double_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wlo_q, wlo_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic            cen_q, cen_d;
    logic            wen_q, wen_d;
    logic            oen_q, oen_d;
    logic [AW-1:0]   a_q, a_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [2*DW-1:0] rsp_rdata_c;

    // SRAM controls are computed from the next state so they are flop outputs during each beat.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        double_d = double_q;
        addr_d   = addr_q;
        wlo_d    = wlo_q;
        hi_d     = hi_q;
        cen_d    = 1'b1;
        wen_d    = 1'b1;
        oen_d    = 1'b1;
        a_d      = a_q;
        dout_d   = dout_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    double_d = bus.req_double;
                    addr_d   = bus.req_addr;
                    wlo_d    = bus.req_wdata[DW-1:0];
                    if (bus.req_double && bus.req_addr[0]) begin
                        state_d = ERR;
                    end else begin
                        state_d = B0;
                        cen_d   = 1'b0;
                        wen_d   = ~bus.req_write;
                        oen_d   = bus.req_write;
                        a_d     = bus.req_addr;
                        dout_d  = bus.req_double ? bus.req_wdata[2*DW-1:DW]
                                                 : bus.req_wdata[DW-1:0];
                    end
                end
            end
            B0: begin
                if (double_q) begin
                    state_d = B1;
                    cen_d   = 1'b0;
                    wen_d   = ~write_q;
                    oen_d   = write_q;
                    a_d     = addr_q + AW'(1);
                    dout_d  = wlo_q;
                end else begin
                    state_d = RSP;
                end
            end
            B1: begin
                state_d = RSP;
                if (!write_q) hi_d = ReadDataMem;
            end
            RSP:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP) || (state_d == ERR);
        rsp_err_d   = (state_d == ERR);
    end

    // SRAM Q for the last beat only arrives during RSP, so read data is a gated pass-through.
    always_comb begin
        rsp_rdata_c = '0;
        if (state_q == RSP && !write_q)
            rsp_rdata_c = {(double_q ? hi_q : DW'(0)), ReadDataMem};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            double_q    <= 1'b0;
            addr_q      <= '0;
            wlo_q       <= '0;
            hi_q        <= '0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            a_q         <= '0;
            dout_q      <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            double_q    <= double_d;
            addr_q      <= addr_d;
            wlo_q       <= wlo_d;
            hi_q        <= hi_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            a_q         <= a_d;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign CEN           = cen_q;
    assign WEN           = wen_q;
    assign OEN           = oen_q;
    assign A             = a_q;
    assign Data2Mem      = dout_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_c;

endmodule
